output_conditioner: RTL and testbench

// Drive-side counterpart of the input conditioner. Takes one-cycle rise/fall

---
 rtl/output_conditioner.sv | 148 ++++++++++++++
 tb/tb_output_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/output_conditioner.sv
// -----------------------------------------------------------------------------
// output_conditioner
//
// Takes one-cycle rise/fall request pulses from core logic and turns them into
// a clean registered output level. After every change, the pin holds its level
// for a minimum dwell of WAITTIME edges. A request that arrives during the
// dwell is kept in a single-entry pending slot, where the last request wins.
// When the dwell ends, the pending entry is either applied or silently
// discarded.
//
// Parameters
//   WAITTIME      minimum number of edges pinout holds a level (>= 1)
//   COUNTERWIDTH  hold counter width; 2**COUNTERWIDTH must exceed WAITTIME
//   INIT_LEVEL    pinout value while reset_n is low
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   setedge    in   one-cycle request to drive pinout high
//   clearedge  in   one-cycle request to drive pinout low
//   pinout     out  conditioned output level (registered)
//   busy       out  high while the dwell after a change is running
//   dropped    out  one-cycle pulse when a request is discarded
// -----------------------------------------------------------------------------
module output_conditioner #(
    parameter int   WAITTIME     = 3,
    parameter int   COUNTERWIDTH = 3,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic setedge,
    input  logic clearedge,
    output logic pinout,
    output logic busy,
    output logic dropped
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [COUNTERWIDTH-1:0] LOAD       = COUNTERWIDTH'(WAITTIME - 1);
    // With a one-edge dwell the pin may change on every edge, so HOLD is never entered.
    localparam bit                      LONG_DWELL = (WAITTIME > 1);

    state_t                  r_state, w_state_n;
    logic [COUNTERWIDTH-1:0] r_cnt, w_cnt_n;
    logic                    r_pin, w_pin_n;
    logic                    r_pend_v, w_pend_v_n;
    logic                    r_pend_tgt, w_pend_tgt_n;
    logic                    r_dropped, w_dropped_n;

    logic w_req;
    logic w_tgt;
    logic w_both;
    logic w_chg;
    logic w_chg_lvl;

    // A request is exactly one of the two pulses. Both pulses together are
    // contradictory and are treated as a discarded request.
    assign w_req  = setedge ^ clearedge;
    assign w_tgt  = setedge;
    assign w_both = setedge & clearedge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pin      <= INIT_LEVEL;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_pin      <= w_pin_n;
            r_pend_v   <= w_pend_v_n;
            r_pend_tgt <= w_pend_tgt_n;
            r_dropped  <= w_dropped_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_pin_n      = r_pin;
        w_pend_v_n   = r_pend_v;
        w_pend_tgt_n = r_pend_tgt;
        w_dropped_n  = w_both;
        w_chg        = 1'b0;
        w_chg_lvl    = r_pin;

        case (r_state)
            IDLE: begin
                if (w_req && (w_tgt != r_pin)) begin
                    w_chg     = 1'b1;
                    w_chg_lvl = w_tgt;
                end
            end
            HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                    if (w_req) begin
                        // Replacing a queued request with the opposite
                        // level loses that request, so report it.
                        if (r_pend_v && (r_pend_tgt != w_tgt)) begin
                            w_dropped_n = 1'b1;
                        end
                        w_pend_tgt_n = w_tgt;
                        w_pend_v_n   = 1'b1;
                    end
                end else begin
                    // Dwell expired on this edge. A fresh request takes
                    // priority over the pending entry, as it would in IDLE.
                    w_state_n  = IDLE;
                    w_pend_v_n = 1'b0;
                    if (w_req) begin
                        if (w_tgt != r_pin) begin
                            w_chg     = 1'b1;
                            w_chg_lvl = w_tgt;
                        end
                    end else if (r_pend_v && (r_pend_tgt != r_pin)) begin
                        w_chg     = 1'b1;
                        w_chg_lvl = r_pend_tgt;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_chg) begin
            w_pin_n = w_chg_lvl;
            w_cnt_n = LOAD;
            if (LONG_DWELL) begin
                w_state_n = HOLD;
            end
        end
    end

    assign pinout  = r_pin;
    assign busy    = (r_state == HOLD);
    assign dropped = r_dropped;

endmodule

// File: tb/tb_output_conditioner.sv
// -----------------------------------------------------------------------------
// tb_output_conditioner
//
// Directed bench for output_conditioner with WAITTIME=3 and INIT_LEVEL=0.
// Each stimulus step drives a request 5 time units after a rising edge. It
// pushes the hand-computed (pinout, busy, dropped) expected after the next
// edge into a scoreboard queue. A monitor pops one entry from the queue 1
// time unit after each rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_output_conditioner;

    typedef struct {
        logic  pin;
        logic  busy;
        logic  drop;
        string name;
    } exp_t;

    logic clk;
    logic reset_n;
    logic setedge;
    logic clearedge;
    logic pinout;
    logic busy;
    logic dropped;

    exp_t sb[$];
    int   checks;
    int   errors;

    output_conditioner #(
        .WAITTIME    (3),
        .COUNTERWIDTH(3),
        .INIT_LEVEL  (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .setedge  (setedge),
        .clearedge(clearedge),
        .pinout   (pinout),
        .busy     (busy),
        .dropped  (dropped)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Scoreboard monitor: one expected entry per edge while stimulus is active.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (pinout !== e.pin || busy !== e.busy || dropped !== e.drop) begin
                errors = errors + 1;
                $display("FAIL %s: got pin=%b busy=%b dropped=%b, want pin=%b busy=%b dropped=%b",
                         e.name, pinout, busy, dropped, e.pin, e.busy, e.drop);
            end
        end
    end

    task automatic step(input logic s, input logic c,
                        input logic ep, input logic eb, input logic ed,
                        input string name);
        exp_t e;
        @(posedge clk);
        #5;
        setedge   = s;
        clearedge = c;
        e.pin  = ep;
        e.busy = eb;
        e.drop = ed;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_now(input logic ep, input logic eb, input logic ed,
                             input string name);
        checks = checks + 1;
        if (pinout !== ep || busy !== eb || dropped !== ed) begin
            errors = errors + 1;
            $display("FAIL %s: got pin=%b busy=%b dropped=%b, want pin=%b busy=%b dropped=%b",
                     name, pinout, busy, dropped, ep, eb, ed);
        end
    endtask

    // Safety net in case something stalls the stimulus process.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        setedge   = 1'b0;
        clearedge = 1'b0;
        #2;
        check_now(1'b0, 1'b0, 1'b0, "reset_init");
        #23;
        reset_n = 1'b1;

        // Single rise: change on first edge, busy for three cycles.
        step(1, 0, 1, 1, 0, "t2_rise");
        step(0, 0, 1, 1, 0, "t2_hold1");
        step(0, 0, 1, 1, 0, "t2_hold2");
        step(0, 0, 1, 0, 0, "t2_idle");
        step(0, 0, 1, 0, 0, "t2_stay");

        // Request for the current level while idle is ignored.
        step(1, 0, 1, 0, 0, "t6_same");
        step(0, 0, 1, 0, 0, "t6_after");

        // Return to 0.
        step(0, 1, 0, 1, 0, "ret_fall");
        step(0, 0, 0, 1, 0, "ret_hold1");
        step(0, 0, 0, 1, 0, "ret_hold2");
        step(0, 0, 0, 0, 0, "ret_idle");

        // Rise, then fall one cycle later: high for exactly three cycles.
        step(1, 0, 1, 1, 0, "t3_rise");
        step(0, 1, 1, 1, 0, "t3_queue");
        step(0, 0, 1, 1, 0, "t3_hold");
        step(0, 0, 0, 1, 0, "t3_fall");
        step(0, 0, 0, 1, 0, "t3_hold_b1");
        step(0, 0, 0, 1, 0, "t3_hold_b2");
        step(0, 0, 0, 0, 0, "t3_idle");

        // Glitch set/clear/set: one rise, one drop for the overwrite.
        step(1, 0, 1, 1, 0, "t4_rise");
        step(0, 1, 1, 1, 0, "t4_queue_clr");
        step(1, 0, 1, 1, 1, "t4_overwrite");
        step(0, 0, 1, 0, 0, "t4_discard");
        step(0, 0, 1, 0, 0, "t4_stay");

        // Both pulses together while idle.
        step(1, 1, 1, 0, 1, "t5_both");
        step(0, 0, 1, 0, 0, "t5_after");

        // A request on the expiry edge acts immediately.
        step(0, 1, 0, 1, 0, "exp_fall");
        step(0, 0, 0, 1, 0, "exp_hold1");
        step(0, 0, 0, 1, 0, "exp_hold2");
        step(1, 0, 1, 1, 0, "exp_req");
        step(0, 0, 1, 1, 0, "exp_hold3");
        step(0, 0, 1, 1, 0, "exp_hold4");
        step(0, 0, 1, 0, 0, "exp_idle");

        // Both pulses during hold keep the pending entry intact.
        step(0, 1, 0, 1, 0, "hb_fall");
        step(1, 0, 0, 1, 0, "hb_queue_set");
        step(1, 1, 0, 1, 1, "hb_both");
        step(0, 0, 1, 1, 0, "hb_apply");
        step(0, 0, 1, 1, 0, "hb_hold1");
        step(0, 0, 1, 1, 0, "hb_hold2");
        step(0, 0, 1, 0, 0, "hb_idle");

        // Reset mid-hold with a pending rise: the queued rise must be lost.
        step(0, 1, 0, 1, 0, "t1_fall");
        step(1, 0, 0, 1, 0, "t1_queue_set");
        @(posedge clk);
        #5;
        setedge   = 1'b0;
        clearedge = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_now(1'b0, 1'b0, 1'b0, "t1_reset");
        @(posedge clk);
        #5;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, "t1_quiet1");
        step(0, 0, 0, 0, 0, "t1_quiet2");
        step(0, 0, 0, 0, 0, "t1_quiet3");
        step(0, 0, 0, 0, 0, "t1_quiet4");

        @(posedge clk);
        #5;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
